// File: rtl/param_div.sv
// Multi-cycle radix-2 restoring divider, signed or unsigned, one quotient bit per clock.
// result_o = {remainder, quotient}; valid while ready_o is high.
module param_div #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_zero_o
);

  typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH:0]   work_q, work_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               neg_quot_q, neg_quot_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div_zero_q, div_zero_d;

  logic               sign1, sign2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     cand;
  logic               ge;
  logic [WIDTH-1:0]   rem_next;
  logic [2*WIDTH:0]   step_res;
  logic [WIDTH-1:0]   quot, rem, quot_fix, rem_fix;

  assign sign1 = signed_div_i & opdata1_i[WIDTH-1];
  assign sign2 = signed_div_i & opdata2_i[WIDTH-1];
  assign mag1  = sign1 ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
  assign mag2  = sign2 ? (~opdata2_i + WIDTH'(1)) : opdata2_i;

  // work = {partial remainder (WIDTH bits), next dividend bit, dividend/quotient shifter}.
  // The top WIDTH+1 bits are already the shifted trial value, so each step is compare+subtract.
  always_comb begin
    cand     = work_q[2*WIDTH:WIDTH];
    ge       = (cand >= {1'b0, divisor_q});
    rem_next = ge ? (cand[WIDTH-1:0] - divisor_q) : cand[WIDTH-1:0];
    step_res = {rem_next, work_q[WIDTH-1:0], ge};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StFree;
      cnt_q      <= '0;
      work_q     <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    unique case (state_q)
      StFree: begin
        if (start_i && !annul_i) begin
          cnt_d = '0;
          if (opdata2_i == '0) begin
            state_d    = StByZero;
            work_d     = '0;
            divisor_d  = '0;
            neg_quot_d = 1'b0;
            neg_rem_d  = 1'b0;
            div_zero_d = 1'b1;
          end else begin
            state_d    = StOn;
            work_d     = {{WIDTH{1'b0}}, mag1, 1'b0};
            divisor_d  = mag2;
            neg_quot_d = sign1 ^ sign2;
            neg_rem_d  = sign1;
            div_zero_d = 1'b0;
          end
        end
      end
      StByZero: begin
        // Zero-divisor path spends two cycles here so ready rises two edges after accept.
        if (annul_i) begin
          state_d = StFree;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = StEnd;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StOn: begin
        if (annul_i) begin
          state_d = StFree;
        end else if (cnt_q == CNT_W'(WIDTH)) begin
          state_d = StEnd;
        end else begin
          work_d = step_res;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      StEnd: begin
        if (annul_i || !start_i) begin
          state_d = StFree;
        end
      end
      default: state_d = StFree;
    endcase
  end

  always_comb begin
    quot       = work_q[WIDTH-1:0];
    rem        = work_q[2*WIDTH:WIDTH+1];
    quot_fix   = neg_quot_q ? (~quot + WIDTH'(1)) : quot;
    rem_fix    = neg_rem_q ? (~rem + WIDTH'(1)) : rem;
    result_o   = '0;
    ready_o    = 1'b0;
    div_zero_o = 1'b0;
    busy_o     = (state_q != StFree);
    if (state_q == StEnd) begin
      ready_o    = 1'b1;
      result_o   = {rem_fix, quot_fix};
      div_zero_o = div_zero_q;
    end
  end

endmodule
